alu_seq_core: RTL

//   Sequential signed ALU feeding the 4-bit sign/magnitude segment decoder.

---
 rtl/alu_pkg.sv | 8 +
 rtl/alu_seq_core_if.sv | 11 +
 rtl/alu_mul_iter.sv | 48 ++++
 rtl/alu_seq_core.sv | 116 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, operand width and FSM states shared by the ALU slice
package alu_pkg;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_NOT = 4'd2, OP_AND = 4'd3,
                              OP_OR = 4'd4, OP_XOR = 4'd5, OP_SLT = 4'd6, OP_EQ = 4'd7,
                              OP_MUL = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/alu_seq_core_if.sv
// alu_seq_core_if: operand handshake and result/flag bus; master drives operands, slave returns results
interface alu_seq_core_if #(parameter int WIDTH = 4);
  import alu_pkg::*;
  logic in_valid, in_ready, acc_sel, out_valid, busy, carry, overflow, zero, err;
  logic [WIDTH-1:0] a, b, result;
  logic [OP_W-1:0] op;
  modport master(output in_valid, a, b, op, acc_sel,
                 input in_ready, out_valid, busy, result, carry, overflow, zero, err);
  modport slave(input in_valid, a, b, op, acc_sel,
                output in_ready, out_valid, busy, result, carry, overflow, zero, err);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: sign-magnitude shift-add multiplier; ports clk, rst, start_i, a_i, b_i -> busy_o, done_o, product_o
module alu_mul_iter #(parameter int WIDTH = 4) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0] mplier_q, ma, mb;
  logic [CW-1:0] cnt_q;
  logic neg_q, busy_q;
  assign ma = a_i[WIDTH-1] ? -a_i : a_i;
  assign mb = b_i[WIDTH-1] ? -b_i : b_i;
  // bit 0 of the multiplier is consumed at start, so WIDTH bits finish after WIDTH-1 further edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= mb[0] ? {{WIDTH{1'b0}}, ma} : '0;
      mcand_q <= {{WIDTH{1'b0}}, ma} << 1;
      mplier_q <= mb >> 1;
      cnt_q <= CW'(1);
      neg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CW'(WIDTH)) busy_q <= 1'b0;
      else begin
        acc_q <= acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  assign busy_o = busy_q;
  assign done_o = busy_q && cnt_q == CW'(WIDTH);
  assign product_o = neg_q ? -acc_q : acc_q;
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential signed ALU (clk, rst, bus: operands in, held result/flags out); ALU_ACC_EN enables acc_sel
module alu_seq_core
  import alu_pkg::*;
#(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  alu_seq_core_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, a_eff, res;
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d, valid_q, valid_d;
  logic c, v, e, accept, start, mul_busy, mul_done;
  logic [WIDTH:0] sum, dif, prod_hi;
  logic [2*WIDTH-1:0] prod;
  assign accept = bus.in_valid & bus.in_ready;
  assign start = accept && bus.op == OP_MUL;
`ifdef ALU_ACC_EN
  // the accumulator is the last completed result, which result_q already holds
  assign a_eff = bus.acc_sel ? result_q : bus.a;
`else
  logic unused_acc_sel;
  assign unused_acc_sel = bus.acc_sel;
  assign a_eff = bus.a;
`endif
  assign sum = {1'b0, a_eff} + {1'b0, bus.b};
  assign dif = {1'b0, a_eff} - {1'b0, bus.b};
  assign prod_hi = prod[2*WIDTH-1:WIDTH-1];
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = a_eff[WIDTH-1] == bus.b[WIDTH-1] && sum[WIDTH-1] != a_eff[WIDTH-1];
      end
      OP_SUB: begin
        res = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = a_eff[WIDTH-1] != bus.b[WIDTH-1] && dif[WIDTH-1] != a_eff[WIDTH-1];
      end
      OP_NOT: res = ~a_eff;
      OP_AND: res = a_eff & bus.b;
      OP_OR:  res = a_eff | bus.b;
      OP_XOR: res = a_eff ^ bus.b;
      OP_SLT: res = WIDTH'($signed(a_eff) < $signed(bus.b));
      OP_EQ:  res = WIDTH'(a_eff == bus.b);
      default: e = 1'b1;
    endcase
  end
  // result and flags change only when an op completes, so the display holds steady during multiply
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    carry_d = carry_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    err_d = err_q;
    valid_d = valid_q;
    if (state_q == S_MUL) begin
      if (mul_done) begin
        state_d = S_DONE;
        result_d = prod[WIDTH-1:0];
        carry_d = 1'b0;
        ovf_d = ~&prod_hi & |prod_hi;
        zero_d = prod[WIDTH-1:0] == '0;
        err_d = 1'b0;
        valid_d = 1'b1;
      end
    end else if (start) begin
      state_d = S_MUL;
      valid_d = 1'b0;
    end else if (accept) begin
      state_d = S_DONE;
      result_d = res;
      carry_d = c;
      ovf_d = v;
      zero_d = ~e && res == '0;
      err_d = e;
      valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      result_q <= '0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      carry_q <= carry_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      err_q <= err_d;
      valid_q <= valid_d;
    end
  end
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .start_i(start), .a_i(a_eff), .b_i(bus.b),
    .busy_o(mul_busy), .done_o(mul_done), .product_o(prod)
  );
  assign bus.in_ready = state_q != S_MUL;
  assign bus.out_valid = valid_q;
  assign bus.busy = mul_busy;
  assign bus.result = result_q;
  assign bus.carry = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero = zero_q;
  assign bus.err = err_q;
endmodule
